// File: rtl/i2c_flush_master.sv
// I2C write master: bytes are queued in a FIFO, and a FLUSH pulse sends START, the address,
// the queued bytes and STOP, with ACK checking after every byte.
module i2c_flush_master #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h82,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             CLK,
    input  logic             GSRn,
    input  logic             WR_EN,
    input  logic [7:0]       WR_DATA,
    input  logic             FLUSH,
    output logic             FULL,
    output logic [CNT_W-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             NACK,
    output logic             SCL_OE,
    output logic             SDA_OE,
    input  logic             SDA_I
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0]    QLAST    = QW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StData,
        StAck,
        StStop,
        StEnd
    } state_t;

    state_t           r_state, w_state_d;
    logic [QW-1:0]    r_qcnt, w_qcnt_d;
    logic [1:0]       r_quarter, w_quarter_d;
    logic [2:0]       r_bit, w_bit_d;
    logic [7:0]       r_shift, w_shift_d;
    logic [CNT_W-1:0] r_remain, w_remain_d;
    logic             r_after_addr, w_after_addr_d;
    logic             r_sda_smp, w_sda_smp_d;
    logic             r_sda_meta, r_sda_sync;
    logic [PW-1:0]    r_wr_ptr, w_wr_ptr_d;
    logic [PW-1:0]    r_rd_ptr, w_rd_ptr_d;
    logic [CNT_W-1:0] r_count, w_count_d;
    logic             r_nack, w_nack_d;
    logic             r_done, w_done_d;
    logic             r_scl_oe, w_scl_oe_d;
    logic             r_sda_oe, w_sda_oe_d;
    logic [7:0]       r_mem [DEPTH];

    logic             w_full;
    logic             w_push;
    logic             w_tick;
    logic [CNT_W-1:0] w_pop_amt;
    logic [PW-1:0]    w_rd_next;

    assign w_full    = (r_count == CNT_FULL);
    assign w_push    = WR_EN && !w_full;
    assign w_tick    = (r_qcnt == QLAST);
    assign w_rd_next = r_rd_ptr + PW'(1);

    always_comb begin
        w_state_d      = r_state;
        w_qcnt_d       = '0;
        w_quarter_d    = r_quarter;
        w_bit_d        = r_bit;
        w_shift_d      = r_shift;
        w_remain_d     = r_remain;
        w_after_addr_d = r_after_addr;
        w_sda_smp_d    = r_sda_smp;
        w_nack_d       = r_nack;
        w_done_d       = 1'b0;
        w_pop_amt      = '0;

        if (r_state != StIdle && r_state != StEnd) begin
            w_qcnt_d = w_tick ? '0 : r_qcnt + QW'(1);
            if (w_tick) begin
                w_quarter_d = r_quarter + 2'd1;
            end
        end

        case (r_state)
            StIdle: begin
                w_quarter_d = 2'd0;
                if (FLUSH && r_count != '0) begin
                    w_state_d  = StStart;
                    w_remain_d = r_count;
                    w_nack_d   = 1'b0;
                end
            end
            StStart: begin
                if (w_tick && r_quarter == 2'd1) begin
                    w_state_d      = StAddr;
                    w_quarter_d    = 2'd0;
                    w_bit_d        = 3'd0;
                    w_shift_d      = {SLAVE_ADDR[7:1], 1'b0};
                    w_after_addr_d = 1'b1;
                end
            end
            StAddr, StData: begin
                if (w_tick && r_quarter == 2'd3) begin
                    w_shift_d = {r_shift[6:0], 1'b0};
                    w_bit_d   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_d = StAck;
                    end
                end
            end
            StAck: begin
                // SCL has been high a full quarter here, so the synced level is settled
                if (w_tick && r_quarter == 2'd2) begin
                    w_sda_smp_d = r_sda_sync;
                end
                if (w_tick && r_quarter == 2'd3) begin
                    w_after_addr_d = 1'b0;
                    w_bit_d        = 3'd0;
                    if (r_sda_smp) begin
                        // Drop every unsent byte of this snapshot, the refused one included
                        w_nack_d   = 1'b1;
                        w_pop_amt  = r_remain;
                        w_remain_d = '0;
                        w_state_d  = StStop;
                    end else if (r_after_addr) begin
                        w_state_d = StData;
                        w_shift_d = r_mem[r_rd_ptr];
                    end else begin
                        w_pop_amt  = CNT_W'(1);
                        w_remain_d = r_remain - CNT_W'(1);
                        if (r_remain == CNT_W'(1)) begin
                            w_state_d = StStop;
                        end else begin
                            w_state_d = StData;
                            w_shift_d = r_mem[w_rd_next];
                        end
                    end
                end
            end
            StStop: begin
                if (w_tick && r_quarter == 2'd2) begin
                    w_state_d = StEnd;
                end
            end
            StEnd: begin
                w_quarter_d = 2'd0;
                w_state_d   = StIdle;
                w_done_d    = 1'b1;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_wr_ptr_d = r_wr_ptr + PW'(w_push);
        w_rd_ptr_d = r_rd_ptr + w_pop_amt[PW-1:0];
        w_count_d  = r_count + CNT_W'(w_push) - w_pop_amt;
    end

    // Pad enables are registered from the next state so the open-drain lines never glitch
    always_comb begin
        w_scl_oe_d = 1'b0;
        w_sda_oe_d = 1'b0;
        case (w_state_d)
            StStart: begin
                w_sda_oe_d = (w_quarter_d == 2'd1);
            end
            StAddr, StData: begin
                w_scl_oe_d = (w_quarter_d == 2'd0) || (w_quarter_d == 2'd3);
                w_sda_oe_d = !w_shift_d[7];
            end
            StAck: begin
                w_scl_oe_d = (w_quarter_d == 2'd0) || (w_quarter_d == 2'd3);
            end
            StStop: begin
                w_scl_oe_d = (w_quarter_d == 2'd0);
                w_sda_oe_d = (w_quarter_d != 2'd2);
            end
            default: begin
                w_scl_oe_d = 1'b0;
                w_sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge GSRn) begin
        if (!GSRn) begin
            r_state      <= StIdle;
            r_qcnt       <= '0;
            r_quarter    <= 2'd0;
            r_bit        <= 3'd0;
            r_shift      <= 8'd0;
            r_remain     <= '0;
            r_after_addr <= 1'b0;
            r_sda_smp    <= 1'b0;
            r_sda_meta   <= 1'b1;
            r_sda_sync   <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_nack       <= 1'b0;
            r_done       <= 1'b0;
            r_scl_oe     <= 1'b0;
            r_sda_oe     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_qcnt       <= w_qcnt_d;
            r_quarter    <= w_quarter_d;
            r_bit        <= w_bit_d;
            r_shift      <= w_shift_d;
            r_remain     <= w_remain_d;
            r_after_addr <= w_after_addr_d;
            r_sda_smp    <= w_sda_smp_d;
            r_sda_meta   <= SDA_I;
            r_sda_sync   <= r_sda_meta;
            r_wr_ptr     <= w_wr_ptr_d;
            r_rd_ptr     <= w_rd_ptr_d;
            r_count      <= w_count_d;
            r_nack       <= w_nack_d;
            r_done       <= w_done_d;
            r_scl_oe     <= w_scl_oe_d;
            r_sda_oe     <= w_sda_oe_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    assign FULL   = w_full;
    assign COUNT  = r_count;
    assign BUSY   = (r_state != StIdle);
    assign DONE   = r_done;
    assign NACK   = r_nack;
    assign SCL_OE = r_scl_oe;
    assign SDA_OE = r_sda_oe;

endmodule

// File: tb/tb_i2c_flush_master.sv
// Directed bench for i2c_flush_master: an ACKing slave model on the wired-AND bus plus a monitor
// that decodes START/STOP/bytes and counts BUSY and DONE cycles.
module tb_i2c_flush_master;

    logic       CLK = 1'b0;
    logic       GSRn;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       FLUSH;
    logic       FULL;
    logic [4:0] COUNT;
    logic       BUSY;
    logic       DONE;
    logic       NACK;
    logic       SCL_OE;
    logic       SDA_OE;
    logic       SDA_I;
    logic       slave_pull = 1'b0;

    i2c_flush_master #(
        .SLAVE_ADDR (8'h82),
        .DEPTH      (16),
        .CLK_DIV    (12),
        .CNT_W      (5)
    ) u_dut (
        .CLK     (CLK),
        .GSRn    (GSRn),
        .WR_EN   (WR_EN),
        .WR_DATA (WR_DATA),
        .FLUSH   (FLUSH),
        .FULL    (FULL),
        .COUNT   (COUNT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .NACK    (NACK),
        .SCL_OE  (SCL_OE),
        .SDA_OE  (SDA_OE),
        .SDA_I   (SDA_I)
    );

    always #25 CLK = ~CLK;

    assign SDA_I = !(SDA_OE || slave_pull);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave model
    int         busy_cyc = 0, done_cnt = 0, oe_cyc = 0, done_at_fall = 0;
    int         start_cnt = 0, stop_cnt = 0, nack_bits = 0, rx_n = 0;
    int         bitcnt = 0, byte_idx = 0, nack_at = -1;
    logic [7:0] shreg = 8'd0;
    logic [7:0] rx [64];
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    logic       bus_scl, bus_sda;

    assign bus_scl = !SCL_OE;
    assign bus_sda = SDA_I;

    always @(negedge CLK) begin
        if (BUSY) busy_cyc <= busy_cyc + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (SCL_OE || SDA_OE) oe_cyc <= oe_cyc + 1;
        if (prev_busy && !BUSY && DONE) done_at_fall <= done_at_fall + 1;
        if (!GSRn) begin
            bitcnt     <= 0;
            byte_idx   <= 0;
            slave_pull <= 1'b0;
        end else if (prev_scl && bus_scl && prev_sda && !bus_sda) begin
            start_cnt <= start_cnt + 1;
            bitcnt    <= 0;
            byte_idx  <= 0;
        end else if (prev_scl && bus_scl && !prev_sda && bus_sda) begin
            stop_cnt <= stop_cnt + 1;
        end else if (!prev_scl && bus_scl) begin
            if (bitcnt < 8) begin
                shreg <= {shreg[6:0], bus_sda};
                if (bitcnt == 7 && rx_n < 64) begin
                    rx[rx_n] <= {shreg[6:0], bus_sda};
                    rx_n     <= rx_n + 1;
                end
            end else if (bus_sda) begin
                nack_bits <= nack_bits + 1;
            end
            bitcnt <= bitcnt + 1;
        end else if (prev_scl && !bus_scl) begin
            if (bitcnt == 8) begin
                slave_pull <= (byte_idx != nack_at);
            end else if (bitcnt == 9) begin
                slave_pull <= 1'b0;
                bitcnt     <= 0;
                byte_idx   <= byte_idx + 1;
            end
        end
        prev_scl  <= bus_scl;
        prev_sda  <= bus_sda;
        prev_busy <= BUSY;
    end

    int b0, d0, f0, o0, s0, p0, k0, r0;

    task automatic snap();
        b0 = busy_cyc; d0 = done_cnt; f0 = done_at_fall; o0 = oe_cyc;
        s0 = start_cnt; p0 = stop_cnt; k0 = nack_bits; r0 = rx_n;
    endtask

    task automatic push(input logic [7:0] d);
        WR_EN   = 1'b1;
        WR_DATA = d;
        @(negedge CLK);
        WR_EN   = 1'b0;
    endtask

    task automatic do_flush();
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (BUSY && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        check_eq(tag, {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int lat;
        int t;
        GSRn = 1'b0; WR_EN = 1'b0; WR_DATA = 8'd0; FLUSH = 1'b0;
        #100;
        @(negedge CLK);
        GSRn = 1'b1;
        @(negedge CLK);

        // 1: reset values, then FLUSH with an empty FIFO
        check_eq("rst_full", {31'd0, FULL}, 32'd0);
        check_eq("rst_count", {27'd0, COUNT}, 32'd0);
        check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("rst_done", {31'd0, DONE}, 32'd0);
        check_eq("rst_nack", {31'd0, NACK}, 32'd0);
        check_eq("rst_scl_oe", {31'd0, SCL_OE}, 32'd0);
        check_eq("rst_sda_oe", {31'd0, SDA_OE}, 32'd0);
        snap();
        do_flush();
        repeat (50) @(negedge CLK);
        check_eq("empty_flush_busy", busy_cyc - b0, 0);
        check_eq("empty_flush_done", done_cnt - d0, 0);
        check_eq("empty_flush_bus", oe_cyc - o0, 0);

        // 2: two data bytes to an ACKing slave
        push(8'hC2);
        push(8'h01);
        check_eq("t2_count", {27'd0, COUNT}, 32'd2);
        snap();
        FLUSH = 1'b1;
        lat = 0;
        while (!SDA_OE && lat < 100) begin
            @(negedge CLK);
            lat++;
            FLUSH = 1'b0;
        end
        check_eq("t2_sda_fall_lat", lat, 13);
        wait_idle("t2_timeout");
        check_eq("t2_busy_cycles", busy_cyc - b0, 1357);
        check_eq("t2_done_pulses", done_cnt - d0, 1);
        check_eq("t2_done_at_fall", done_at_fall - f0, 1);
        check_eq("t2_starts", start_cnt - s0, 1);
        check_eq("t2_stops", stop_cnt - p0, 1);
        check_eq("t2_nbytes", rx_n - r0, 3);
        check_eq("t2_addr", {24'd0, rx[r0]}, 32'h82);
        check_eq("t2_d0", {24'd0, rx[r0+1]}, 32'hC2);
        check_eq("t2_d1", {24'd0, rx[r0+2]}, 32'h01);
        check_eq("t2_acks", nack_bits - k0, 0);
        check_eq("t2_count_end", {27'd0, COUNT}, 32'd0);
        check_eq("t2_nack", {31'd0, NACK}, 32'd0);

        // 3: overfill, then drain 16 bytes in order
        for (int i = 0; i < 16; i++) push(8'(i));
        check_eq("t3_full", {31'd0, FULL}, 32'd1);
        check_eq("t3_count16", {27'd0, COUNT}, 32'd16);
        push(8'h10);
        check_eq("t3_count_drop", {27'd0, COUNT}, 32'd16);
        snap();
        do_flush();
        wait_idle("t3_timeout");
        check_eq("t3_nbytes", rx_n - r0, 17);
        check_eq("t3_addr", {24'd0, rx[r0]}, 32'h82);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3_d%0d", i), {24'd0, rx[r0+1+i]}, i);
        end
        check_eq("t3_count_end", {27'd0, COUNT}, 32'd0);
        check_eq("t3_full_end", {31'd0, FULL}, 32'd0);

        // 4: slave refuses the second data byte of four
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        nack_at = 2;
        snap();
        do_flush();
        wait_idle("t4_timeout");
        nack_at = -1;
        check_eq("t4_nack", {31'd0, NACK}, 32'd1);
        check_eq("t4_count", {27'd0, COUNT}, 32'd0);
        check_eq("t4_nbytes", rx_n - r0, 3);
        check_eq("t4_last_byte", {24'd0, rx[r0+2]}, 32'hA1);
        check_eq("t4_busy_cycles", busy_cyc - b0, 1357);
        check_eq("t4_stops", stop_cnt - p0, 1);
        check_eq("t4_done_pulses", done_cnt - d0, 1);
        push(8'h5A);
        do_flush();
        check_eq("t4b_busy", {31'd0, BUSY}, 32'd1);
        check_eq("t4b_nack_clr", {31'd0, NACK}, 32'd0);
        wait_idle("t4b_timeout");
        check_eq("t4b_nack_end", {31'd0, NACK}, 32'd0);

        // 5: bytes pushed while busy stay for the next flush
        push(8'hB0); push(8'hB1); push(8'hB2);
        snap();
        do_flush();
        push(8'hB3); push(8'hB4);
        wait_idle("t5_timeout");
        check_eq("t5_nbytes", rx_n - r0, 4);
        check_eq("t5_last_byte", {24'd0, rx[r0+3]}, 32'hB2);
        check_eq("t5_count", {27'd0, COUNT}, 32'd2);

        // 6: reset in the middle of a data bit
        do_flush();
        t = 0;
        while (!(byte_idx == 1 && bitcnt == 3 && SCL_OE) && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        check_eq("t6_reached_data", {31'd0, (t < 5000)}, 32'd1);
        #2;
        GSRn = 1'b0;
        #1;
        check_eq("t6_scl_oe", {31'd0, SCL_OE}, 32'd0);
        check_eq("t6_sda_oe", {31'd0, SDA_OE}, 32'd0);
        check_eq("t6_busy", {31'd0, BUSY}, 32'd0);
        check_eq("t6_count", {27'd0, COUNT}, 32'd0);
        @(negedge CLK);
        GSRn = 1'b1;
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_flush_master.md
Name: i2c_flush_master

Overview:
Synthesisable, parametrised I2C write master that replaces bench-only buffer/flush behaviour with hardware. Host logic queues bytes into an internal FIFO, then pulses FLUSH. The block then issues START, the slave address byte (write), every queued byte, and STOP, checking the ACK after each byte. It sits between the system controller and the open-drain SDA/SCL pads, in front of flasher-class I2C slaves.

Parameters:
SLAVE_ADDR  8'h82  8-bit slave address; bit 0 is ignored and forced to 0 (write)
DEPTH       16     FIFO depth in bytes; power of 2, minimum 2
CLK_DIV     12     CLK cycles per quarter SCL bit; 20 MHz / (4*12) ≈ 417 kHz
CNT_W       5      width of COUNT; must equal log2(DEPTH)+1

Ports:
CLK        input   1      system clock
GSRn       input   1      asynchronous active-low reset
WR_EN      input   1      push WR_DATA into FIFO; ignored when FULL
WR_DATA    input   8      byte to queue
FLUSH      input   1      start a transaction; ignored when BUSY
FULL       output  1      FIFO full
COUNT      output  CNT_W  bytes currently queued
BUSY       output  1      transaction in progress
DONE       output  1      1-cycle pulse at end of transaction
NACK       output  1      sticky; last transaction aborted on NACK
SCL_OE     output  1      1 = pull SCL low; 0 = release
SDA_OE     output  1      1 = pull SDA low; 0 = release
SDA_I      input   1      sampled SDA pad level

Behaviour:
- Reset (GSRn=0, async) values: FIFO empty, COUNT=0, FULL=0, BUSY=0, DONE=0, NACK=0, SCL_OE=0, SDA_OE=0, FSM=IDLE. Reset asserted mid-transaction releases both lines immediately; no STOP is generated.
- FIFO push:
  - A push happens when WR_EN=1 and FULL=0. COUNT updates the next cycle.
  - Pointers wrap modulo DEPTH.
  - FULL = (COUNT==DEPTH). WR_EN while FULL is dropped silently.
- FLUSH:
  - Accepted only when BUSY=0 and COUNT>0. BUSY rises the next cycle.
  - FLUSH with COUNT=0 does nothing: no bus activity and no DONE.
  - On acceptance, NACK is cleared and N=COUNT is snapshotted. Exactly N bytes are sent.
  - Bytes pushed during BUSY stay queued for the next FLUSH.
- Bit timing: one quarter = CLK_DIV cycles. Each bit takes 4 quarters:
  - Q0: drive SDA, SCL low.
  - Q1, Q2: SCL released.
  - Q3: SCL low.
  - SDA changes only while SCL is low.
- FSM states: IDLE → START → ADDR → ACK → DATA → ACK → ... → STOP → IDLE.
  - START: SDA falls while SCL is high, then SCL falls (2 quarters).
  - ADDR / DATA: 8 bits, MSB first. Address byte is {SLAVE_ADDR[7:1],1'b0}.
  - ACK: SDA released. SDA_I is sampled at the end of Q2 (SCL high). 0 = ACK, 1 = NACK.
  - On ACK after a data byte: pop the FIFO and decrement the remaining count. If remaining is 0, go to STOP; else go to DATA.
  - On NACK (address or data): set NACK=1, then go to STOP. The un-sent bytes of the snapshot (including the NACKed byte) are discarded from the FIFO. Bytes pushed after FLUSH are kept.
  - STOP: SDA low with SCL low, release SCL, then release SDA (3 quarters). DONE pulses the cycle BUSY falls.
- Simultaneous events:
  - WR_EN and a pop in the same cycle: COUNT stays unchanged.
  - WR_EN and FLUSH in the same cycle: the new byte is not included in N.
- Latency: FLUSH-to-first-SDA-fall = 1 + CLK_DIV cycles.
  - Total for N bytes = 1 + CLK_DIV*(2 + 36*(N+1) + 3) cycles, where each byte plus its ACK is 9 bits × 4 quarters = 36 quarters.

Test Plan:
1. Reset then idle: GSRn low 100 ns, release -> all outputs 0, COUNT=0; FLUSH with COUNT=0 -> SCL_OE/SDA_OE stay 0, no DONE.
2. Two-byte write to an ACKing slave model at 0x82: push 0x82-prefixed pair {0xC2, 0x01} (address-type byte, LED-sync data) -> bus shows START, 0x82, ACK, 0xC2, ACK, 0x01, ACK, STOP; BUSY high for exactly 1+12*(5+108)=1357 cycles; DONE one pulse; COUNT=0; NACK=0.
3. Fill FIFO with 17 pushes (0x00..0x10) -> FULL=1 after 16th push, COUNT=16, 0x10 dropped; flush sends 0x00..0x0F in order.
4. Slave NACKs the 2nd data byte of 4 queued -> STOP right after that ACK slot, NACK=1, COUNT=0; next successful FLUSH clears NACK.
5. Push 3 bytes, FLUSH, push 2 more during BUSY -> only 3 sent, COUNT=2 after DONE.
6. Assert GSRn low mid-DATA bit -> SCL_OE=SDA_OE=0 same cycle, BUSY=0, COUNT=0.
